// File: rtl/rx_to_mem_pkg.sv
// ============================================================================
// Module      : rx_to_mem_pkg
// Description : Shared constants and state encoding for the UART-to-memory
//               operand loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_to_mem_pkg;

    localparam int c_rows_default      = 2;
    localparam int c_cols_default      = 2;
    localparam int c_num_elems_default = c_rows_default * c_cols_default;
    localparam int c_num_bytes_default = 2 * c_num_elems_default;

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_wait_byte = 3'd1;
    localparam logic [2:0] c_st_write     = 3'd2;
    localparam logic [2:0] c_st_next      = 3'd3;
    localparam logic [2:0] c_st_check     = 3'd4;
    localparam logic [2:0] c_st_done      = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = c_st_idle,
        ST_WAIT_BYTE = c_st_wait_byte,
        ST_WRITE     = c_st_write,
        ST_NEXT      = c_st_next,
        ST_CHECK     = c_st_check,
        ST_DONE      = c_st_done
    } state_t;

    // Data bytes in one load: matrix A followed by matrix B.
    function automatic int num_bytes(input int rows, input int cols);
        return 2 * rows * cols;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_to_mem_if.sv
// ============================================================================
// Module      : rx_to_mem_if
// Description : Receiver-side inputs and memory write port of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rx_to_mem_if #(
    parameter int ADDR_W = 6
);
    logic              start;
    logic              rx_ready;
    logic [7:0]        rx_data;
    logic              write;
    logic [ADDR_W-1:0] write_address;
    logic [7:0]        write_value;
    logic              mat_sel;
    logic [ADDR_W-1:0] values_recv_count;
    logic              busy;
    logic              load_done;
    logic              err;

    modport master (
        input  start, rx_ready, rx_data,
        output write, write_address, write_value, mat_sel,
               values_recv_count, busy, load_done, err
    );

    modport slave (
        output start, rx_ready, rx_data,
        input  write, write_address, write_value, mat_sel,
               values_recv_count, busy, load_done, err
    );
endinterface

`default_nettype wire

// File: rtl/rx_to_mem_sync_edge.sv
// ============================================================================
// Module      : sync_edge
// Description : Three-flop synchronizer with a one-cycle rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge (
    input  logic slow_clk,
    input  logic rst,
    input  logic i_async,
    output logic o_pulse
);
    logic r_q1;
    logic r_q2;
    logic r_q3;

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_q1 <= 1'b0;
            r_q2 <= 1'b0;
            r_q3 <= 1'b0;
        end else begin
            r_q1 <= i_async;
            r_q2 <= r_q1;
            r_q3 <= r_q2;
        end
    end

    assign o_pulse = r_q2 & ~r_q3;
endmodule

`default_nettype wire

// File: rtl/rx_to_mem.sv
// ============================================================================
// Module      : rx_to_mem
// Description : Loads received bytes into operand memory as matrix A then B.
//               Define RX_CHECKSUM_EN to verify a trailing mod-256 checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_to_mem
    import rx_to_mem_pkg::*;
#(
    parameter int ROWS   = c_rows_default,
    parameter int COLS   = c_cols_default,
    parameter int ADDR_W = 6
) (
    input  logic           slow_clk,
    input  logic           rst,
    rx_to_mem_if.master    bus
);
    localparam logic [ADDR_W-1:0] c_num_elems = ADDR_W'(ROWS * COLS);
    localparam logic [ADDR_W-1:0] c_num_bytes = ADDR_W'(num_bytes(ROWS, COLS));

    logic              w_start_pulse;
    logic              w_rx_pulse;
    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] w_count_inc;
    logic [7:0]        r_value;

    sync_edge u_start_sync (
        .slow_clk (slow_clk),
        .rst      (rst),
        .i_async  (bus.start),
        .o_pulse  (w_start_pulse)
    );

    sync_edge u_rx_sync (
        .slow_clk (slow_clk),
        .rst      (rst),
        .i_async  (bus.rx_ready),
        .o_pulse  (w_rx_pulse)
    );

    assign w_count_inc = r_count + 1'b1;

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:      if (w_start_pulse) w_next_state = ST_WAIT_BYTE;
            ST_WAIT_BYTE: if (w_rx_pulse)    w_next_state = ST_WRITE;
            ST_WRITE:     w_next_state = ST_NEXT;
            ST_NEXT: begin
                if (w_count_inc == c_num_bytes) begin
`ifdef RX_CHECKSUM_EN
                    w_next_state = ST_CHECK;
`else
                    w_next_state = ST_DONE;
`endif
                end else begin
                    w_next_state = ST_WAIT_BYTE;
                end
            end
`ifdef RX_CHECKSUM_EN
            ST_CHECK:     if (w_rx_pulse) w_next_state = ST_DONE;
`endif
            ST_DONE:      w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // Count is held at zero while idle so every load starts at address 0.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_value <= 8'h00;
        end else begin
            if (r_state == ST_IDLE) begin
                r_count <= '0;
            end
            if (r_state == ST_NEXT) begin
                r_count <= w_count_inc;
            end
            if (r_state == ST_WAIT_BYTE && w_rx_pulse) begin
                r_value <= bus.rx_data;
            end
        end
    end

`ifdef RX_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_err;

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            r_sum <= 8'h00;
            r_err <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_start_pulse) begin
                r_sum <= 8'h00;
                r_err <= 1'b0;
            end
            if (r_state == ST_WAIT_BYTE && w_rx_pulse) begin
                r_sum <= r_sum + bus.rx_data;
            end
            // The checksum byte is compared only; it never reaches memory.
            if (r_state == ST_CHECK && w_rx_pulse && bus.rx_data != r_sum) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.write             = (r_state == ST_WRITE);
    assign bus.write_address     = r_count;
    assign bus.write_value       = r_value;
    assign bus.mat_sel           = (r_count >= c_num_elems);
    assign bus.values_recv_count = r_count;
    assign bus.busy              = (r_state != ST_IDLE);
    assign bus.load_done         = (r_state == ST_DONE);
endmodule

`default_nettype wire

// File: tb/tb_rx_to_mem.sv
// ============================================================================
// Module      : tb_rx_to_mem
// Description : Randomized self-checking bench for rx_to_mem (2x2 matrices);
//               honours RX_CHECKSUM_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_to_mem;
    localparam int ROWS   = 2;
    localparam int COLS   = 2;
    localparam int ADDR_W = 6;
    localparam int N      = ROWS * COLS;
    localparam int T      = 2 * N;

    logic slow_clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 slow_clk = ~slow_clk;

    rx_to_mem_if #(.ADDR_W(ADDR_W)) bus ();

    rx_to_mem #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .ADDR_W (ADDR_W)
    ) dut (
        .slow_clk (slow_clk),
        .rst      (rst),
        .bus      (bus)
    );

    // Observed memory-port activity.
    int wr_addr[$];
    int wr_val[$];
    int wr_sel[$];
    int done_pulses;
    int done_count;

    always @(negedge slow_clk) begin
        if (bus.write === 1'b1) begin
            wr_addr.push_back(int'(bus.write_address));
            wr_val.push_back(int'(bus.write_value));
            wr_sel.push_back(int'(bus.mat_sel));
        end
        if (bus.load_done === 1'b1) begin
            done_pulses++;
            done_count = int'(bus.values_recv_count);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge slow_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_val.delete();
        wr_sel.delete();
        done_pulses = 0;
        done_count  = -1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        tick(hold);
        bus.rx_ready = 1'b0;
        tick(int'($urandom_range(3, 5)));
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(2);
        bus.start = 1'b0;
        tick(3);
    endtask

    // Expected: byte i lands at address i, matrix B from index N onward.
    task automatic check_load(input string tag, input logic [7:0] exp_q[$]);
        check({tag, "_nwrites"}, wr_addr.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
            check($sformatf("%s_val%0d", tag, i), wr_val[i], int'(exp_q[i]));
            check($sformatf("%s_sel%0d", tag, i), wr_sel[i], (i >= N) ? 1 : 0);
        end
        check({tag, "_done_pulses"}, done_pulses, 1);
        check({tag, "_done_count"}, done_count, T);
        check({tag, "_busy_after"}, bus.busy, 1'b0);
    endtask

    function automatic logic [7:0] sum_of(input logic [7:0] q[$]);
        int s = 0;
        foreach (q[i]) s += int'(q[i]);
        return 8'(s % 256);
    endfunction

    logic [7:0] data_q[$];

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        clear_mon();
        tick(3);
        check("rst_write", bus.write, 1'b0);
        check("rst_addr", bus.write_address, 0);
        check("rst_value", bus.write_value, 0);
        check("rst_mat_sel", bus.mat_sel, 1'b0);
        check("rst_count", bus.values_recv_count, 0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_load_done", bus.load_done, 1'b0);
        check("rst_err", bus.err, 1'b0);
        rst = 1'b0;
        tick(2);

        // Bytes with no load in progress are dropped.
        send_byte(8'hAA, 3);
        send_byte(8'hBB, 3);
        check("idle_nwrites", wr_addr.size(), 0);
        check("idle_count", bus.values_recv_count, 0);
        check("idle_busy", bus.busy, 1'b0);

        // Directed load 0x01..0x08.
        clear_mon();
        pulse_start();
        check("dir_busy", bus.busy, 1'b1);
        data_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        foreach (data_q[i]) send_byte(data_q[i], 3);
`ifdef RX_CHECKSUM_EN
        check("dir_sum_model", sum_of(data_q), 8'h24);
        send_byte(8'h24, 3);
`endif
        tick(3);
        check_load("dir", data_q);
        check("dir_err", bus.err, 1'b0);

        // A byte after the load has terminated is not written.
        send_byte(8'h5A, 3);
        check("post_nwrites", wr_addr.size(), T);
        check("post_busy", bus.busy, 1'b0);

        // Randomized loads; the first one holds rx_ready high for a long time.
        for (int l = 0; l < 3; l++) begin
            clear_mon();
            pulse_start();
            data_q.delete();
            for (int i = 0; i < T; i++) data_q.push_back(8'($urandom));
            for (int i = 0; i < T; i++) begin
                send_byte(data_q[i], (l == 0 && i == 0) ? 25 : int'($urandom_range(3, 6)));
                if (l == 0 && i == 0) check("long_hold_nwrites", wr_addr.size(), 1);
            end
`ifdef RX_CHECKSUM_EN
            send_byte(sum_of(data_q), 3);
`endif
            tick(3);
            check_load($sformatf("rnd%0d", l), data_q);
            check($sformatf("rnd%0d_err", l), bus.err, 1'b0);
        end

        // Reset in the middle of a load.
        clear_mon();
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 3);
        check("midrst_partial", wr_addr.size(), 3);
        rst = 1'b1;
        tick(1);
        check("midrst_write", bus.write, 1'b0);
        check("midrst_count", bus.values_recv_count, 0);
        check("midrst_addr", bus.write_address, 0);
        check("midrst_value", bus.write_value, 0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_mat_sel", bus.mat_sel, 1'b0);
        rst = 1'b0;
        tick(2);
        clear_mon();
        pulse_start();
        data_q.delete();
        for (int i = 0; i < T; i++) data_q.push_back(8'($urandom));
        foreach (data_q[i]) send_byte(data_q[i], 3);
`ifdef RX_CHECKSUM_EN
        send_byte(sum_of(data_q), 3);
`endif
        tick(3);
        check_load("after_rst", data_q);

        // A second start while busy is ignored.
        clear_mon();
        pulse_start();
        data_q.delete();
        for (int i = 0; i < T; i++) data_q.push_back(8'($urandom));
        for (int i = 0; i < N; i++) send_byte(data_q[i], 3);
        pulse_start();
        for (int i = N; i < T; i++) send_byte(data_q[i], 3);
`ifdef RX_CHECKSUM_EN
        send_byte(sum_of(data_q), 3);
`endif
        tick(3);
        check_load("restart", data_q);
        tick(10);
        check("restart_idle", bus.busy, 1'b0);

`ifdef RX_CHECKSUM_EN
        // Wrong checksum: err set, no extra write, done still pulses.
        clear_mon();
        pulse_start();
        data_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        foreach (data_q[i]) send_byte(data_q[i], 3);
        send_byte(8'h25, 3);
        tick(3);
        check_load("bad_sum", data_q);
        check("bad_sum_err", bus.err, 1'b1);
        tick(5);
        check("bad_sum_err_held", bus.err, 1'b1);
        clear_mon();
        pulse_start();
        check("err_cleared_on_start", bus.err, 1'b0);
        data_q.delete();
        for (int i = 0; i < T; i++) data_q.push_back(8'($urandom));
        foreach (data_q[i]) send_byte(data_q[i], 3);
        send_byte(sum_of(data_q) + 8'(1 + $urandom_range(0, 254)), 3);
        tick(3);
        check_load("rnd_bad_sum", data_q);
        check("rnd_bad_sum_err", bus.err, 1'b1);
`else
        check("no_cksum_err", bus.err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/rx_to_mem.md
# rx_to_mem

Receive-side loader for the matrix multiplier: takes bytes delivered by the UART receiver and writes them, in arrival order, into the operand memory as matrix A followed by matrix B. It is the inbound counterpart of the memory-to-UART transmit path and drives the same `memory` write port (`write`, `write_address`, `write_value`). All control runs on `slow_clk`; receiver outputs are synchronized internally.

## Interface
- `ROWS`, default 2: rows per matrix.
- `COLS`, default 2: columns per matrix.
- `ADDR_W`, default 6: memory address width; requires 2·ROWS·COLS ≤ 2^ADDR_W − 1.
- `slow_clk` in 1: system clock for this block.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: level request to begin a load; rising edge detected internally.
- `rx_ready` in 1: receiver byte-valid level, asynchronous to `slow_clk`.
- `rx_data` in 8: received byte; stable while `rx_ready` is high.
- `write` out 1: one-cycle memory write strobe.
- `write_address` out ADDR_W: memory address for current write.
- `write_value` out 8: byte to write.
- `mat_sel` out 1: 0 while loading A, 1 while loading B.
- `values_recv_count` out ADDR_W: data bytes written so far in this load.
- `busy` out 1: high from accepted start until DONE exits.
- `load_done` out 1: one-cycle pulse at end of load.
- `err` out 1: sticky checksum-mismatch flag (see Configuration).

## Operation
- N = ROWS·COLS; total data bytes T = 2N. Address = byte index 0..T−1; A occupies 0..N−1, B N..T−1; `mat_sel` = (count ≥ N).
- States: IDLE, WAIT_BYTE, WRITE, NEXT, CHECK (macro only), DONE.
- IDLE: count cleared to 0; on start rising edge → WAIT_BYTE, `err` cleared.
- WAIT_BYTE: on rx rising-edge pulse capture `rx_data` into `write_value` → WRITE.
- WRITE: `write`=1, `write_address`=count; → NEXT.
- NEXT: count+1; if new count = T → CHECK (macro) or DONE, else → WAIT_BYTE.
- DONE: `load_done`=1 for one cycle → IDLE.
- Bytes arriving in IDLE, WRITE, NEXT, DONE are dropped (receiver must pace ≥3 cycles between bytes).
- `start` edges while busy ignored.

## Timing
- Reset values: all outputs 0, state IDLE, synchronizer flops 0. Memory contents untouched by reset.
- `rx_ready` passes 3 flops (r1,r2,r3); pulse = r2 & ~r3. Rising `rx_ready` sampled at edge k → byte captured at edge k+2 → `write` high in cycle k+2..k+3 → count updated at edge k+4.
- `start` uses same 3-flop edge detector: 2-cycle latency to leave IDLE.
- `write_address`/`write_value` stable throughout the `write` cycle.
- Reset mid-load: immediate return to IDLE, count 0, partial data left in memory; next load rewrites from address 0.
- Count never wraps: T reached always terminates the load.

## Configuration
- `RX_CHECKSUM_EN` defined: after T data bytes, CHECK waits for one extra byte; compared to 8-bit modulo-256 sum of the T data bytes; mismatch sets `err` (held until next accepted start); checksum byte never written to memory; `load_done` pulses regardless.
- Undefined: no CHECK state, no sum register, `err` tied 0, DONE follows last write.

## Structure
- Shared package: state encodings, `ROWS`/`COLS` defaults, derived T and N constants.
- One sub-module: `sync_edge` (3-flop synchronizer + rising-edge pulse), instantiated twice (`start`, `rx_ready`).

## Test plan
- Reset then start, send 0x01,0x02,0x03,0x04,0x05,0x06,0x07,0x08 → writes to addresses 0..7 with those values; `mat_sel` 0 for first four, 1 for last four; one `load_done` pulse; count 8.
- Bytes 0xAA,0xBB sent before start → no `write` strobes; count stays 0.
- Assert `rst` after 3 bytes of a load → outputs 0 next cycle; new load writes from address 0.
- Second start pulse mid-load → ignored; load completes with exactly 8 writes.
- With `RX_CHECKSUM_EN`: data 0x01..0x08 then 0x24 → `err`=0; same data then 0x25 → `err`=1, no write at address 8, `load_done` pulses.
- `rx_ready` held high across many cycles for one byte → exactly one write.
